// File: rtl/alu_frame_interface.sv
// Frame interface between a byte UART and a combinational ALU: gathers operand A,
// operand B and an opcode from received bytes, then streams the ALU result back out.
module alu_frame_interface #(
    parameter int DBIT    = 8,
    parameter int NB_DATA = 16,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [DBIT-1:0]    i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_busy,
    output logic               o_frame_err
);

    localparam int BYTES = NB_DATA / DBIT;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        RX_A,
        RX_B,
        RX_OP,
        EXEC,
        TX_SEND,
        TX_WAIT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   tx_idx_q;
    logic [TO_W-1:0]    to_q;
    logic [NB_DATA-1:0] shadow_a_q;
    logic [NB_DATA-1:0] shadow_b_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] shift_q;
    logic               tx_start_q;
    logic [DBIT-1:0]    tx_data_q;
    logic               busy_q;
    logic               frame_err_q;

    // The inter-byte timer only runs once part of a frame is held.
    logic frame_started;
    assign frame_started = (state_q != RX_A) || (idx_q != '0);

    // NOTE: every register here is written with <= so all of them update from the
    // same pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge i_clk) begin
        tx_start_q  <= 1'b0;
        frame_err_q <= 1'b0;

        if (!i_reset) begin
            state_q    <= RX_A;
            idx_q      <= '0;
            tx_idx_q   <= '0;
            to_q       <= '0;
            // NOTE: the shadow registers are cleared too, so an aborted frame leaves nothing behind.
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                RX_A, RX_B, RX_OP: begin
                    if (i_rx_done_tick) begin
                        to_q <= '0;
                        if (state_q == RX_OP) begin
                            data_a_q <= shadow_a_q;
                            data_b_q <= shadow_b_q;
                            op_q     <= i_rx_data[NB_OP-1:0];
                            idx_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= EXEC;
                        end else begin
                            for (int k = 0; k < BYTES; k++) begin
                                if (idx_q == IDX_W'(k)) begin
                                    if (state_q == RX_A) shadow_a_q[k*DBIT +: DBIT] <= i_rx_data;
                                    else                 shadow_b_q[k*DBIT +: DBIT] <= i_rx_data;
                                end
                            end
                            if (idx_q == LAST_IDX) begin
                                idx_q   <= '0;
                                state_q <= (state_q == RX_A) ? RX_B : RX_OP;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end else if (frame_started) begin
                        if (to_q == TO_LAST) begin
                            shadow_a_q  <= '0;
                            shadow_b_q  <= '0;
                            idx_q       <= '0;
                            to_q        <= '0;
                            state_q     <= RX_A;
                            frame_err_q <= 1'b1;
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end
                end

                EXEC: begin
                    frame_err_q <= i_rx_done_tick;
                    shift_q     <= i_alu_result;
                    tx_idx_q    <= '0;
                    state_q     <= TX_SEND;
                end

                TX_SEND: begin
                    frame_err_q <= i_rx_done_tick;
                    tx_start_q  <= 1'b1;
                    tx_data_q   <= shift_q[DBIT-1:0];
                    state_q     <= TX_WAIT;
                end

                TX_WAIT: begin
                    frame_err_q <= i_rx_done_tick;
                    if (i_tx_done_tick) begin
                        shift_q <= shift_q >> DBIT;
                        if (tx_idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            state_q <= RX_A;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            state_q  <= TX_SEND;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= RX_A;
                end
            endcase
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_operation = op_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_alu_frame_interface.sv
// Bench for alu_frame_interface: directed frames pinned with literal values, then
// randomized traffic compared every cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_alu_frame_interface;

    localparam int DBIT    = 8;
    localparam int NB_DATA = 16;
    localparam int NB_OP   = 6;
    localparam int TIMEOUT = 20;
    localparam int BYTES   = NB_DATA / DBIT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance stimulus and outputs
    logic               rst_n    = 1'b0;
    logic               rx_valid = 1'b0;
    logic [7:0]         rx_byte  = '0;
    logic [15:0]        alu      = '0;
    logic               tx_done  = 1'b0;
    logic [15:0]        o_data_a, o_data_b;
    logic [5:0]         o_operation;
    logic               o_tx_start, o_busy, o_frame_err;
    logic [7:0]         o_tx_data;

    alu_frame_interface #(.DBIT(DBIT), .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_rx_done_tick(rx_valid), .i_rx_data(rx_byte),
        .i_alu_result(alu), .i_tx_done_tick(tx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_operation(o_operation),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_frame_err(o_frame_err)
    );

    // Single-byte-operand instance
    logic       rst8 = 1'b0, rx_v8 = 1'b0, tx_done8 = 1'b0;
    logic [7:0] rx_d8 = '0, alu8 = '0;
    logic [7:0] a8, b8, txd8;
    logic [5:0] op8;
    logic       start8, busy8, err8;

    alu_frame_interface #(.DBIT(8), .NB_DATA(8), .NB_OP(6), .TIMEOUT(TIMEOUT)) dut8 (
        .i_clk(clk), .i_reset(rst8), .i_rx_done_tick(rx_v8), .i_rx_data(rx_d8),
        .i_alu_result(alu8), .i_tx_done_tick(tx_done8),
        .o_data_a(a8), .o_data_b(b8), .o_operation(op8),
        .o_tx_start(start8), .o_tx_data(txd8), .o_busy(busy8), .o_frame_err(err8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame bytes held in a list, a quiet-cycle count, and a
    // transmit schedule expressed as cycles-until-next-start.
    logic [7:0]  fbuf [2*BYTES];
    int          fcnt = 0, quiet = 0, countdown = 0, sent = 0;
    bit          m_busy = 0, awaiting = 0, m_start = 0, m_err = 0;
    logic [15:0] m_result = '0, m_a = '0, m_b = '0;
    logic [5:0]  m_op = '0;
    logic [7:0]  m_txd = '0;
    bit          cmp_en = 0;

    task automatic model_step();
        m_start = 0;
        m_err   = 0;
        if (!rst_n) begin
            fcnt = 0; quiet = 0; countdown = 0; sent = 0;
            m_busy = 0; awaiting = 0;
            m_a = '0; m_b = '0; m_op = '0;
        end else if (m_busy) begin
            if (rx_valid) m_err = 1;
            if (countdown > 0) begin
                if (countdown == 2) m_result = alu;
                countdown--;
                if (countdown == 0) begin
                    m_start  = 1;
                    m_txd    = 8'(m_result >> (8 * sent));
                    sent++;
                    awaiting = 1;
                end
            end else if (awaiting && tx_done) begin
                awaiting = 0;
                if (sent == BYTES) m_busy = 0;
                else countdown = 1;
            end
        end else begin
            if (rx_valid) begin
                quiet = 0;
                if (fcnt < 2 * BYTES) begin
                    fbuf[fcnt] = rx_byte;
                    fcnt++;
                end else begin
                    m_a = '0;
                    m_b = '0;
                    for (int i = 0; i < BYTES; i++) begin
                        m_a = m_a | (16'(fbuf[i]) << (8 * i));
                        m_b = m_b | (16'(fbuf[BYTES + i]) << (8 * i));
                    end
                    m_op      = rx_byte[5:0];
                    fcnt      = 0;
                    m_busy    = 1;
                    countdown = 2;
                    sent      = 0;
                end
            end else if (fcnt > 0) begin
                if (quiet == TIMEOUT - 1) begin
                    m_err = 1;
                    fcnt  = 0;
                    quiet = 0;
                end else begin
                    quiet++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("data_a",    o_data_a,    m_a);
            check("data_b",    o_data_b,    m_b);
            check("operation", o_operation, m_op);
            check("busy",      o_busy,      m_busy);
            check("frame_err", o_frame_err, m_err);
            check("tx_start",  o_tx_start,  m_start);
            if (m_start) check("tx_data", o_tx_data, m_txd);
        end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic done);
        rx_valid = v;
        rx_byte  = d;
        tx_done  = done;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b0);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (o_tx_start !== 1'b1 && n < 20) begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end
        check(name, o_tx_start, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (o_busy === 1'b1 && n < 300) begin
            tick(1'b0, 8'h00, $urandom_range(0, 2) == 0);
            n++;
        end
        check("drain busy", o_busy, 0);
    endtask

    task automatic tick8(input logic v, input logic [7:0] d, input logic done);
        rx_v8    = v;
        rx_d8    = d;
        tx_done8 = done;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        int starts;
        int rate;

        // Reset, with a byte offered that must be ignored
        rst_n = 1'b0;
        tick(1'b1, 8'hA5, 1'b0);
        cmp_en = 1;
        tick(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        check("rst data_a", o_data_a, 0);
        check("rst data_b", o_data_b, 0);
        check("rst op",     o_operation, 0);
        check("rst busy",   o_busy, 0);
        check("rst start",  o_tx_start, 0);

        // Basic frame with a two-byte result
        alu = 16'h68AC;
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        check("a held before commit", o_data_a, 0);
        send(8'h20);
        check("commit a",  o_data_a, 16'h1234);
        check("commit b",  o_data_b, 16'h5678);
        check("commit op", o_operation, 6'h20);
        check("commit busy", o_busy, 1);
        tick(1'b0, 8'h00, 1'b0);
        check("no start in exec", o_tx_start, 0);
        tick(1'b0, 8'h00, 1'b0);
        check("start at commit+2", o_tx_start, 1);
        check("tx low byte", o_tx_data, 8'hAC);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        wait_start("second start");
        check("tx high byte", o_tx_data, 8'h68);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        check("idle after tx", o_busy, 0);

        // Timeout after a partial frame, then a clean frame
        send(8'h34); send(8'h12);
        errs = 0;
        repeat (TIMEOUT - 1) begin
            tick(1'b0, 8'h00, 1'b0);
            errs += int'(o_frame_err);
        end
        check("no early timeout", errs, 0);
        tick(1'b0, 8'h00, 1'b0);
        check("timeout pulse", o_frame_err, 1);
        check("a kept on timeout", o_data_a, 16'h1234);
        tick(1'b0, 8'h00, 1'b0);
        check("timeout one cycle", o_frame_err, 0);
        send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h20);
        check("after timeout a", o_data_a, 16'h0001);
        check("after timeout b", o_data_b, 16'h0002);
        drain();

        // Byte in the last quiet cycle is accepted
        send(8'h34); send(8'h12);
        repeat (TIMEOUT - 1) tick(1'b0, 8'h00, 1'b0);
        send(8'h78);
        check("edge byte no err", o_frame_err, 0);
        send(8'h56); send(8'h20);
        check("edge frame a", o_data_a, 16'h1234);
        check("edge frame b", o_data_b, 16'h5678);
        drain();

        // Byte dropped while transmitting
        alu = 16'hBEEF;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h07);
        wait_start("drop first start");
        check("drop tx low", o_tx_data, 8'hEF);
        tick(1'b0, 8'h00, 1'b0);
        send(8'h55);
        check("drop err", o_frame_err, 1);
        check("drop a kept", o_data_a, 16'h0201);
        tick(1'b0, 8'h00, 1'b1);
        wait_start("drop second start");
        check("drop tx high", o_tx_data, 8'hBE);
        tick(1'b0, 8'h00, 1'b1);
        check("drop done", o_busy, 0);

        // Reset mid-frame and mid-transmit
        send(8'h01); send(8'h02); send(8'h03);
        rst_n = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        check("midrst a",  o_data_a, 0);
        check("midrst b",  o_data_b, 0);
        check("midrst op", o_operation, 0);
        alu = 16'h1234;
        send(8'h09); send(8'h00); send(8'h08); send(8'h00); send(8'h01);
        check("post-rst a", o_data_a, 16'h0009);
        wait_start("post-rst start");
        check("post-rst tx", o_tx_data, 8'h34);
        rst_n = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        starts = 0;
        repeat (5) begin
            tick(1'b0, 8'h00, 1'b1);
            starts += int'(o_tx_start);
        end
        check("no start after reset", starts, 0);
        check("idle after reset", o_busy, 0);

        // Randomized traffic
        rate = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 2;
                    1:       rate = 6;
                    default: rate = 25;
                endcase
            end
            rst_n = ($urandom_range(0, 599) != 0);
            alu   = 16'($urandom);
            tick($urandom_range(0, rate - 1) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
        end
        rst_n = 1'b1;
        drain();

        // Single-byte operands: 3-byte frame, one result byte
        rst8 = 1'b1;
        alu8 = 8'h9C;
        tick8(1'b1, 8'h11, 1'b0);
        tick8(1'b1, 8'h22, 1'b0);
        tick8(1'b1, 8'h05, 1'b0);
        check("nb8 a",  a8, 8'h11);
        check("nb8 b",  b8, 8'h22);
        check("nb8 op", op8, 6'h05);
        starts = 0;
        for (int n = 0; n < 10 && start8 !== 1'b1; n++) tick8(1'b0, 8'h00, 1'b0);
        check("nb8 start", start8, 1);
        check("nb8 tx", txd8, 8'h9C);
        tick8(1'b0, 8'h00, 1'b0);
        tick8(1'b0, 8'h00, 1'b1);
        check("nb8 done", busy8, 0);
        repeat (5) begin
            tick8(1'b0, 8'h00, 1'b1);
            starts += int'(start8);
        end
        check("nb8 single byte", starts, 0);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
